coeff_bank_loader: RTL and testbench
====================================

# coeff_bank_loader

- Consumer end of the FIR coefficient interface. Takes the 13-tap IEEE-754 single-precision coefficient set from the coefficient generator.
- Waits until the set has been stable for a programmable number of cycles, then writes it serially into a shadow bank. It swaps shadow and active banks on a sample boundary.
- Serves glitch-free tap reads to the FIR MAC datapath, which never sees a half-updated coefficient set.

## Interface
- SETTLE_CYCLES, default 8: consecutive unchanged input cycles required before loading (1..255).
- NTAPS, fixed 13: taps per set; tap k occupies coeff_in[32k+31:32k].
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; reset asserts when low.
- coeff_in  in  416  flat coefficient set from the generator, tap 0 in the LSBs.
- sample_strobe  in  1  one-cycle pulse marking a FIR sample boundary; the only point where a bank swap may occur.
- tap_addr  in  4  tap index for MAC read (0..12).
- tap_data  out  32  registered coefficient of the active bank at tap_addr.
- load_busy  out  1  high in SETTLE, LOAD and WAIT_SWAP.
- bank_valid  out  1  sticky; set at the first swap after reset.
- swap_pulse  out  1  one-cycle pulse in the cycle the swap takes effect.
- sym_err  out  1  sticky symmetry-violation flag (see Configuration).

## Operation
- Storage:
  - Two banks of 13x32 registers; `act_sel` selects the active bank.
  - `prev` register (416b) holds coeff_in from the previous cycle.
- IDLE:
  - If coeff_in != prev: go to SETTLE with settle_cnt=0.
  - Else if coeff_in != active-bank contents: go to SETTLE with settle_cnt=0.
  - Else stay in IDLE.
- SETTLE:
  - coeff_in != prev: settle_cnt clears to 0.
  - Otherwise settle_cnt increments.
  - settle_cnt reaching SETTLE_CYCLES-1 on an unchanged cycle: go to LOAD with idx=0.
- LOAD:
  - Each cycle, write prev[idx] into shadow[idx] and increment idx.
  - After the idx=12 write, go to WAIT_SWAP.
  - Any cycle with coeff_in != prev: abort to SETTLE with settle_cnt=0. Shadow bank contents are then don't-care; the active bank is untouched.
- WAIT_SWAP:
  - On sample_strobe: toggle act_sel, pulse swap_pulse, set bank_valid, go to IDLE.
  - Input changes here are ignored until IDLE. IDLE then re-detects them via the active-bank comparison.
- Tap reads:
  - tap_data <= active[tap_addr] every cycle.
  - tap_addr 13..15 returns 32'h0.
- Coefficient values are never altered; the block does no arithmetic.

## Timing
- Reset (async, low): all outputs 0; banks 0; prev 0; act_sel 0; state IDLE; counters 0.
- Read latency: 1 cycle from tap_addr to tap_data.
- Minimum latency, from a stable new set first presented to the swap:
  - 1 (prev capture) + SETTLE_CYCLES (SETTLE) + 13 (LOAD) + wait for sample_strobe.
- Swap timing:
  - The swap happens on the edge where sample_strobe=1 in WAIT_SWAP.
  - A read issued in that same cycle returns the old bank.
  - The next cycle's read returns the new bank.
- sample_strobe in IDLE, SETTLE or LOAD is ignored.
- sample_strobe in the first WAIT_SWAP cycle is honored.
- Reset mid-LOAD: immediate return to reset state; the previous active contents are lost, and bank_valid=0 until a new swap.

## Configuration
- COEFF_SYM_CHECK_EN defined:
  - Entering WAIT_SWAP requires shadow[k]==shadow[12-k] bit-exact for k=0..5.
  - On mismatch: set sym_err, discard the load, return to IDLE with no swap.
  - IDLE does not restart SETTLE until coeff_in changes again; this prevents an endless retry loop.
- COEFF_SYM_CHECK_EN undefined: no check; sym_err is tied to 0.

## Test plan
- Reset, then hold coeff_in with all taps 0x3F800000 and SETTLE_CYCLES=8:
  - load_busy rises;
  - 22 cycles later the state is WAIT_SWAP;
  - a sample_strobe 5 cycles later gives swap_pulse, bank_valid=1, and tap_addr=6 reads 0x3F800000 on the following cycle.
- Toggle tap 3 every 4 cycles for 40 cycles with SETTLE_CYCLES=8: no LOAD is entered, the active bank is unchanged, and load_busy stays high.
- Change tap 0 to 0x3DCCCCCD in the 5th LOAD cycle: abort to SETTLE; the completed reload and swap carry the new value; reads of old taps stay stable until the swap.
- Pulse sample_strobe during SETTLE and LOAD: no swap_pulse. Then strobe in WAIT_SWAP: a read issued in the strobe cycle returns the old value, and a read one cycle later returns the new value.
- Assert reset low mid-LOAD (idx=7): all outputs are 0 within the same cycle (async), and tap reads return 0 afterwards.
- With COEFF_SYM_CHECK_EN, set tap 2 = 0x3F000000 and tap 10 = 0x3E800000:
  - after the load, sym_err=1 and there is no swap_pulse;
  - state IDLE persists until the input changes.
  - Without the macro, the same stimulus swaps normally and sym_err=0.

Source files
------------

// File: rtl/coeff_bank_loader.sv
// ---------------------------------------------------------------------------
// coeff_bank_loader
//
// Consumer end of the FIR coefficient interface. Watches the 13-tap
// single-precision coefficient set from the generator. Once the set has held
// still for SETTLE_CYCLES cycles, it copies the set tap by tap into the
// shadow bank. It then swaps shadow and active banks on a sample boundary, so
// the MAC datapath never reads a half-updated set.
//
// Optional feature macro: COEFF_SYM_CHECK_EN. When defined, a freshly loaded
// shadow bank must be symmetric (tap k == tap 12-k, bit-exact) before it may
// be swapped in. A non-symmetric set raises sym_err and is discarded.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   coeff_in       in   416b flat coefficient set, tap k at [32k+31:32k]
//   sample_strobe  in   one-cycle FIR sample boundary pulse (swap point)
//   tap_addr       in   tap index for MAC read (0..12; 13..15 read as 0)
//   tap_data       out  registered active-bank coefficient at tap_addr
//   load_busy      out  high in SETTLE, LOAD and WAIT_SWAP
//   bank_valid     out  sticky, set at the first swap after reset
//   swap_pulse     out  one-cycle pulse in the cycle the new bank is active
//   sym_err        out  sticky symmetry-violation flag (0 without the macro)
//   dbg_state_o    out  FSM state: 0 IDLE, 1 SETTLE, 2 LOAD, 3 WAIT_SWAP
//
// Handshake: there is no back-pressure. coeff_in is sampled every cycle, and
// a coefficient set counts as accepted only once it has been stable long
// enough to load. sample_strobe is honoured only in WAIT_SWAP.
// ---------------------------------------------------------------------------
module coeff_bank_loader #(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [415:0] coeff_in,
    input  logic         sample_strobe,
    input  logic [3:0]   tap_addr,
    output logic [31:0]  tap_data,
    output logic         load_busy,
    output logic         bank_valid,
    output logic         swap_pulse,
    output logic         sym_err,
    output logic [1:0]   dbg_state_o
);

    localparam int NTAPS = 13;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_LOAD      = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [415:0]  prev_q;
    logic [31:0]   bank_q [2][NTAPS];
    logic          act_sel_q, act_sel_d;
    logic [7:0]    settle_cnt_q, settle_cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic          bank_valid_q, bank_valid_d;
    logic          swap_pulse_q, swap_pulse_d;
    logic [31:0]   tap_data_q, tap_data_d;
    logic          shadow_we;
    logic          in_changed, act_diff;
    logic          sym_ok, sym_fail, sym_hold;

    assign in_changed = (coeff_in != prev_q);

    // The input differs from what the MAC is using now. This catches changes
    // that arrived while a swap was pending.
    always_comb begin
        act_diff = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            if (coeff_in[32*k +: 32] != bank_q[act_sel_q][k]) act_diff = 1'b1;
        end
    end

    always_comb begin
        tap_data_d = 32'h0;
        if (tap_addr < 4'd13) tap_data_d = bank_q[act_sel_q][tap_addr];
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        idx_d        = idx_q;
        act_sel_d    = act_sel_q;
        bank_valid_d = bank_valid_q;
        swap_pulse_d = 1'b0;
        shadow_we    = 1'b0;
        sym_fail     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_changed || (act_diff && !sym_hold)) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (in_changed) begin
                    settle_cnt_d = 8'd0;
                end else if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_LOAD: begin
                if (in_changed) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 8'd0;
                end else begin
                    shadow_we = 1'b1;
                    if (idx_q == 4'd12) begin
                        if (sym_ok) begin
                            state_d = ST_WAIT_SWAP;
                        end else begin
                            state_d  = ST_IDLE;
                            sym_fail = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (sample_strobe) begin
                    act_sel_d    = ~act_sel_q;
                    swap_pulse_d = 1'b1;
                    bank_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            act_sel_q    <= 1'b0;
            settle_cnt_q <= 8'd0;
            idx_q        <= 4'd0;
            bank_valid_q <= 1'b0;
            swap_pulse_q <= 1'b0;
            tap_data_q   <= 32'h0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NTAPS; k++) bank_q[b][k] <= 32'h0;
            end
        end else begin
            state_q      <= state_d;
            prev_q       <= coeff_in;
            act_sel_q    <= act_sel_d;
            settle_cnt_q <= settle_cnt_d;
            idx_q        <= idx_d;
            bank_valid_q <= bank_valid_d;
            swap_pulse_q <= swap_pulse_d;
            tap_data_q   <= tap_data_d;
            if (shadow_we) bank_q[~act_sel_q][idx_q] <= prev_q[32*idx_q +: 32];
        end
    end

`ifdef COEFF_SYM_CHECK_EN
    logic sym_err_q, sym_hold_q;

    // LOAD aborts on any input change, so prev_q has held still through every
    // write of this load. Checking prev_q is therefore the same as checking
    // the finished shadow bank, including the tap 12 word written this cycle.
    always_comb begin
        sym_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (prev_q[32*k +: 32] != prev_q[32*(12-k) +: 32]) sym_ok = 1'b0;
        end
    end

    // After a rejected set, IDLE must not retry until the input moves again.
    // Otherwise the active-bank mismatch would restart SETTLE forever.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_err_q  <= 1'b0;
            sym_hold_q <= 1'b0;
        end else begin
            if (sym_fail) sym_err_q <= 1'b1;
            if (sym_fail)        sym_hold_q <= 1'b1;
            else if (in_changed) sym_hold_q <= 1'b0;
        end
    end

    assign sym_hold = sym_hold_q;
    assign sym_err  = sym_err_q;
`else
    assign sym_ok   = 1'b1;
    assign sym_hold = 1'b0;
    // sym_ok is constant 1 here, so sym_fail, and with it sym_err, is constant 0.
    assign sym_err  = sym_fail;
`endif

    assign tap_data    = tap_data_q;
    assign load_busy   = (state_q != ST_IDLE);
    assign bank_valid  = bank_valid_q;
    assign swap_pulse  = swap_pulse_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_coeff_bank_loader.sv
// ---------------------------------------------------------------------------
// Directed bench for coeff_bank_loader (SETTLE_CYCLES = 8).
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_coeff_bank_loader;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic [415:0] coeff_in;
    logic         sample_strobe;
    logic [3:0]   tap_addr;
    logic [31:0]  tap_data;
    logic         load_busy;
    logic         bank_valid;
    logic         swap_pulse;
    logic         sym_err;
    logic [1:0]   dbg_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    coeff_bank_loader #(.SETTLE_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .coeff_in      (coeff_in),
        .sample_strobe (sample_strobe),
        .tap_addr      (tap_addr),
        .tap_data      (tap_data),
        .load_busy     (load_busy),
        .bank_valid    (bank_valid),
        .swap_pulse    (swap_pulse),
        .sym_err       (sym_err),
        .dbg_state_o   (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input string tag);
        for (int n = 0; n < 200 && dbg_state !== target; n++) tick();
        check(tag, {30'b0, dbg_state}, {30'b0, target});
    endtask

    function automatic logic [415:0] fill(input logic [31:0] v);
        logic [415:0] r;
        for (int k = 0; k < 13; k++) r[32*k +: 32] = v;
        return r;
    endfunction

    logic saw_load, busy_all, saw_swap, stay_idle;
    logic [415:0] v;

    initial begin
        reset         = 1'b0;
        coeff_in      = '0;
        sample_strobe = 1'b0;
        tap_addr      = 4'd0;
        #12;
        check("rst_tap_data",   tap_data,   32'h0);
        check("rst_load_busy",  load_busy,  0);
        check("rst_bank_valid", bank_valid, 0);
        check("rst_swap_pulse", swap_pulse, 0);
        check("rst_sym_err",    sym_err,    0);
        check("rst_state",      dbg_state,  S_IDLE);

        // First load: all taps 1.0
        tick();
        reset    = 1'b1;
        coeff_in = fill(32'h3F800000);
        tick();
        check("busy_rises",   load_busy, 1);
        check("first_settle", dbg_state, S_SETTLE);
        repeat (20) tick();
        check("edge21_load", dbg_state, S_LOAD);
        tick();
        check("edge22_wait",   dbg_state,  S_WAIT);
        check("pre_swap_valid", bank_valid, 0);
        repeat (4) tick();
        check("wait_holds", dbg_state, S_WAIT);
        sample_strobe = 1'b1;
        tap_addr      = 4'd6;
        tick();
        sample_strobe = 1'b0;
        check("swap1_pulse",    swap_pulse, 1);
        check("swap1_valid",    bank_valid, 1);
        check("swap1_old_read", tap_data,   32'h0);
        check("swap1_idle",     dbg_state,  S_IDLE);
        tick();
        check("swap1_new_read", tap_data,   32'h3F800000);
        check("swap1_pulse_end", swap_pulse, 0);
        tap_addr = 4'd13;
        tick();
        check("addr13_zero", tap_data, 32'h0);
        tap_addr = 4'd12;
        tick();
        check("addr12_read", tap_data, 32'h3F800000);

        // Toggling tap 3 every 4 cycles must never reach LOAD
        tap_addr = 4'd3;
        saw_load = 1'b0;
        busy_all = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) coeff_in[127:96] = ((i / 4) % 2 == 0) ? 32'h3F000000 : 32'h40400000;
            tick();
            if (dbg_state == S_LOAD) saw_load = 1'b1;
            if (!load_busy) busy_all = 1'b0;
        end
        check("toggle_no_load",   saw_load,  0);
        check("toggle_busy",      busy_all,  1);
        check("toggle_active_t3", tap_data,  32'h3F800000);

        // Abort in the 5th LOAD cycle, then strobes in SETTLE and LOAD
        wait_state(S_LOAD, "reach_load_a");
        repeat (4) tick();
        coeff_in[31:0] = 32'h3DCCCCCD;
        tick();
        check("abort_to_settle", dbg_state, S_SETTLE);
        tap_addr = 4'd0;
        tick();
        check("old_t0_settle", tap_data, 32'h3F800000);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("strobe_settle_no_swap", swap_pulse, 0);
        check("strobe_settle_state",   dbg_state,  S_SETTLE);
        wait_state(S_LOAD, "reach_load_b");
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("strobe_load_no_swap", swap_pulse, 0);
        check("strobe_load_state",   dbg_state,  S_LOAD);
        wait_state(S_WAIT, "reach_wait_b");
        check("old_t0_wait", tap_data, 32'h3F800000);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("strobe_cycle_old", tap_data,   32'h3F800000);
        check("swap2_pulse",      swap_pulse, 1);
        tick();
        check("after_swap_new_t0", tap_data, 32'h3DCCCCCD);
        tap_addr = 4'd3;
        tick();
        check("after_swap_t3", tap_data, 32'h40400000);

        // Asynchronous reset in the middle of LOAD (idx 7)
        coeff_in = fill(32'h40000000);
        wait_state(S_LOAD, "reach_load_c");
        repeat (7) tick();
        #2 reset = 1'b0;
        #1;
        check("midrst_tap_data",   tap_data,   32'h0);
        check("midrst_load_busy",  load_busy,  0);
        check("midrst_bank_valid", bank_valid, 0);
        check("midrst_state",      dbg_state,  S_IDLE);
        coeff_in = '0;
        tick();
        reset    = 1'b1;
        tap_addr = 4'd6;
        tick();
        tick();
        check("postrst_read", tap_data,   32'h0);
        check("postrst_idle", dbg_state,  S_IDLE);
        check("postrst_valid", bank_valid, 0);

        // Non-symmetric set: tap 2 = 0.5, tap 10 = 0.25
        v = fill(32'h3F800000);
        v[95:64]   = 32'h3F000000;
        v[351:320] = 32'h3E800000;
        coeff_in   = v;
        wait_state(S_LOAD, "reach_load_sym");
        repeat (13) tick();
`ifdef COEFF_SYM_CHECK_EN
        check("sym_reject_state", dbg_state, S_IDLE);
        check("sym_err_set",      sym_err,   1);
        check("sym_no_pulse",     swap_pulse, 0);
        saw_swap  = 1'b0;
        stay_idle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            if (swap_pulse) saw_swap = 1'b1;
            if (dbg_state != S_IDLE) stay_idle = 1'b0;
        end
        check("sym_never_swaps", saw_swap,   0);
        check("sym_idle_holds",  stay_idle,  1);
        check("sym_no_valid",    bank_valid, 0);
        coeff_in[351:320] = 32'h3F000000;
        tick();
        check("sym_rearm_settle", dbg_state, S_SETTLE);
        check("sym_err_sticky",   sym_err,   1);
`else
        check("nosym_wait",    dbg_state, S_WAIT);
        check("nosym_err_low", sym_err,   0);
        tap_addr      = 4'd10;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("nosym_pulse", swap_pulse, 1);
        tick();
        check("nosym_t10",     tap_data, 32'h3E800000);
        check("nosym_err_end", sym_err,  0);
        saw_swap  = 1'b0;
        stay_idle = 1'b1;
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
